ahb_gpio_resp_ctrl: RTL

AHB_GPIO_RESP_CTRL -- requirements
Module: ahb_gpio_resp_ctrl

---
 rtl/ahb_pkg.sv | 60 ++++++
 rtl/ahb_gpio_resp_ctrl_if.sv | 30 +++
 rtl/ahb_gpio_resp_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared types and helpers for the AHB GPIO response controller.
package ahb_pkg;

    // Bus-side states: (HREADYOUT,HRESP) = IDLE(1,0) NOT_READY(0,0) ERROR(0,1) ERROR_LAST(1,1)
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        ERROR_LAST = 2'b01,
        NOT_READY  = 2'b10,
        ERROR      = 2'b11
    } states_t;

    // Registered response outputs that travel together with the state
    typedef struct packed {
        logic hreadyout;
        logic hresp;
        logic req;
    } resp_t;

    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    // Output values that belong to each state
    function automatic resp_t state_resp(input states_t s);
        resp_t r;
        r = '{hreadyout: 1'b1, hresp: 1'b0, req: 1'b0};
        case (s)
            NOT_READY:  r = '{hreadyout: 1'b0, hresp: 1'b0, req: 1'b1};
            ERROR:      r = '{hreadyout: 1'b0, hresp: 1'b1, req: 1'b0};
            ERROR_LAST: r = '{hreadyout: 1'b1, hresp: 1'b1, req: 1'b0};
            default:    r = '{hreadyout: 1'b1, hresp: 1'b0, req: 1'b0};
        endcase
        return r;
    endfunction

    // Oversized, misaligned, or in the hole between the two register windows
    function automatic logic decode_error(input logic [2:0]  size,
                                          input logic [31:0] addr,
                                          input logic [31:0] lo_end,
                                          input logic [31:0] hi_start);
        logic err;
        err = 1'b0;
        if (size > SIZE_WORD) begin
            err = 1'b1;
        end else if (size == SIZE_WORD && addr[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (size == SIZE_HALF && addr[0]) begin
            err = 1'b1;
        end
        if (addr > lo_end && addr < hi_start) begin
            err = 1'b1;
        end
        return err;
    endfunction

    // Counter increment that sticks at all-ones
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ahb_gpio_resp_ctrl_if.sv
// AHB slave-side bus plus the simple register-file request/ack handshake.
interface ahb_gpio_resp_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  HSEL;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic                  reg_req;
    logic                  reg_write;
    logic [1:0]            reg_size;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic                  reg_ack;
    logic                  reg_err;

    modport slave (
        input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HREADY, reg_ack, reg_err,
        output HREADYOUT, HRESP, reg_req, reg_write, reg_size, reg_addr
    );

    modport master (
        output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HREADY, reg_ack, reg_err,
        input  HREADYOUT, HRESP, reg_req, reg_write, reg_size, reg_addr
    );

endinterface

// File: rtl/ahb_gpio_resp_ctrl.sv
// AHB response controller: decodes transfers, hands valid ones to the
// register file, and generates wait states or two-cycle ERROR responses.
module ahb_gpio_resp_ctrl
    import ahb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 12,
    parameter logic [ADDR_WIDTH-1:0] LO_END       = 12'h3FF,
    parameter logic [ADDR_WIDTH-1:0] HI_START     = 12'hFD0,
    parameter int                    WAIT_TIMEOUT = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_gpio_resp_ctrl_if.slave   bus,
    output logic [7:0]            err_count
);

    localparam int                WAIT_W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

    states_t               state;
    resp_t                 resp;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  write_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  accept;
    logic                  dec_err;

    assign accept  = bus.HSEL & bus.HTRANS[1] & bus.HREADY & resp.hreadyout;
    assign dec_err = decode_error(bus.HSIZE, 32'(bus.HADDR), 32'(LO_END), 32'(HI_START));

    assign bus.HREADYOUT = resp.hreadyout;
    assign bus.HRESP     = resp.hresp;
    assign bus.reg_req   = resp.req;
    assign bus.reg_write = write_q;
    assign bus.reg_size  = size_q;
    assign bus.reg_addr  = addr_q;

    // Response FSM with registered outputs, wait-state timeout and error counter
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            resp      <= state_resp(IDLE);
            write_q   <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wait_cnt  <= '0;
            err_count <= 8'h00;
        end else begin
            case (state)
                IDLE, ERROR_LAST: begin
                    if (accept && dec_err) begin
                        state     <= ERROR;
                        resp      <= state_resp(ERROR);
                        err_count <= sat_inc(err_count);
                    end else if (accept) begin
                        state    <= NOT_READY;
                        resp     <= state_resp(NOT_READY);
                        write_q  <= bus.HWRITE;
                        size_q   <= bus.HSIZE[1:0];
                        addr_q   <= bus.HADDR;
                        wait_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        resp  <= state_resp(IDLE);
                    end
                end
                NOT_READY: begin
                    if (bus.reg_ack && !bus.reg_err) begin
                        state <= IDLE;
                        resp  <= state_resp(IDLE);
                    end else if (bus.reg_ack || wait_cnt == WAIT_LAST) begin
                        state     <= ERROR;
                        resp      <= state_resp(ERROR);
                        err_count <= sat_inc(err_count);
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    state <= ERROR_LAST;
                    resp  <= state_resp(ERROR_LAST);
                end
                default: begin
                    state <= IDLE;
                    resp  <= state_resp(IDLE);
                end
            endcase
        end
    end

endmodule
